// File: rtl/sp_matmul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sp_matmul_sequencer: issues row-major (row,col) reads for an NxN product, |
// | tags them through the scalar_product latency and captures each result.    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module sp_matmul_sequencer #(
  parameter int NBITS = 4,
  parameter int NDATA = 4,
  parameter int LAT   = 3,
  localparam int IW   = (NDATA > 1) ? $clog2(NDATA) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_hold,
  output logic               o_rd_en,
  output logic [IW-1:0]      o_rd_row,
  output logic [IW-1:0]      o_rd_col,
  input  logic [2*NBITS-1:0] i_sp_out,
  output logic               o_res_valid,
  output logic [2*NBITS-1:0] o_res_data,
  output logic [IW-1:0]      o_res_row,
  output logic [IW-1:0]      o_res_col,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [IW-1:0] c_LAST = IW'(NDATA - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_issue;
  logic [IW-1:0]      r_row;
  logic [IW-1:0]      r_col;
  logic [LAT:0]       r_tag_v;
  logic [IW-1:0]      r_tag_row [0:LAT];
  logic [IW-1:0]      r_tag_col [0:LAT];
  logic               r_res_valid;
  logic [2*NBITS-1:0] r_res_data;
  logic [IW-1:0]      r_res_row;
  logic [IW-1:0]      r_res_col;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_issue = !i_hold;
        if (w_issue && (r_row == c_LAST) && (r_col == c_LAST)) w_state_nxt = S_DRAIN;
      end
      // Once the last tag has left the pipeline, the capture register holds the final element.
      S_DRAIN: if (!(|r_tag_v) && r_res_valid) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || ((r_state == S_IDLE) && i_start)) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_issue) begin
      if (r_col == c_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Shifts every cycle; held-off cycles travel down as bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_row[i] <= '0;
        r_tag_col[i] <= '0;
      end
    end else begin
      for (int i = LAT; i > 0; i--) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
      end
      r_tag_v[0]   <= w_issue;
      r_tag_row[0] <= r_row;
      r_tag_col[0] <= r_col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_row   <= '0;
      r_res_col   <= '0;
    end else begin
      r_res_valid <= r_tag_v[LAT];
      if (r_tag_v[LAT]) begin
        r_res_data <= i_sp_out;
        r_res_row  <= r_tag_row[LAT];
        r_res_col  <= r_tag_col[LAT];
      end
    end
  end

  assign o_rd_en     = w_issue;
  assign o_rd_row    = r_row;
  assign o_rd_col    = r_col;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_row   = r_res_row;
  assign o_res_col   = r_res_col;
  assign o_busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign o_done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sp_matmul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sp_matmul_sequencer: self-checking bench for sp_matmul_sequencer.      |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_sp_matmul_sequencer;

  localparam int NBITS = 4;
  localparam int NDATA = 4;
  localparam int LAT   = 3;
  localparam int IW    = 2;
  localparam int RW    = 2 * NBITS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0, i_hold = 1'b0;
  logic          o_rd_en, o_res_valid, o_busy, o_done;
  logic [IW-1:0] o_rd_row, o_rd_col, o_res_row, o_res_col;
  logic [RW-1:0] i_sp_out, o_res_data;

  logic          s1_start = 1'b0;
  logic          s1_rd_en, s1_res_valid, s1_busy, s1_done;
  logic [0:0]    s1_rd_row, s1_rd_col, s1_res_row, s1_res_col;
  logic [RW-1:0] s1_sp_out, s1_res_data;

  int total = 0;
  int bad   = 0;
  int A  [NDATA][NDATA];
  int Bc [NDATA][NDATA];
  int a1 = 0, b1 = 0;
  logic [RW-1:0] obs_c [NDATA][NDATA];
  bit hold_pat [128];
  logic [RW-1:0] dly  [0:LAT];
  logic [RW-1:0] dly1 [0:LAT];

  always #5 clk = ~clk;

  sp_matmul_sequencer #(.NBITS(NBITS), .NDATA(NDATA), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_hold(i_hold),
    .o_rd_en(o_rd_en), .o_rd_row(o_rd_row), .o_rd_col(o_rd_col),
    .i_sp_out(i_sp_out), .o_res_valid(o_res_valid), .o_res_data(o_res_data),
    .o_res_row(o_res_row), .o_res_col(o_res_col), .o_busy(o_busy), .o_done(o_done)
  );

  sp_matmul_sequencer #(.NBITS(NBITS), .NDATA(1), .LAT(LAT)) dut1 (
    .clk(clk), .reset(reset), .i_start(s1_start), .i_hold(1'b0),
    .o_rd_en(s1_rd_en), .o_rd_row(s1_rd_row), .o_rd_col(s1_rd_col),
    .i_sp_out(s1_sp_out), .o_res_valid(s1_res_valid), .o_res_data(s1_res_data),
    .o_res_row(s1_res_row), .o_res_col(s1_res_col), .o_busy(s1_busy), .o_done(s1_done)
  );

  function automatic logic [RW-1:0] cref(input int r, input int c);
    int s = 0;
    for (int k = 0; k < NDATA; k++) s += A[r][k] * Bc[c][k];
    return RW'(s);
  endfunction

  // Operand source plus behavioural scalar_product; non-request cycles feed garbage.
  always @(posedge clk) begin
    for (int k = LAT; k > 0; k--) begin
      dly[k]  <= dly[k-1];
      dly1[k] <= dly1[k-1];
    end
    dly[0]  <= o_rd_en  ? cref(int'(o_rd_row), int'(o_rd_col)) : RW'($urandom);
    dly1[0] <= s1_rd_en ? RW'(a1 * b1) : RW'($urandom);
  end
  assign i_sp_out  = dly[LAT];
  assign s1_sp_out = dly1[LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < NDATA; r++)
      for (int k = 0; k < NDATA; k++) begin
        A[r][k]  = int'($urandom_range(15, 0));
        Bc[r][k] = int'($urandom_range(15, 0));
      end
  endtask

  task automatic set_holds(input int mode);
    for (int i = 0; i < 128; i++)
      hold_pat[i] = (mode == 2) ? ($urandom_range(3, 0) == 0) : 1'b0;
    if (mode == 1) begin
      hold_pat[3] = 1'b1;
      hold_pat[4] = 1'b1;
    end
  endtask

  // One run starting with a start pulse in cycle 0; expectations follow from the hold pattern.
  task automatic run(input int start_always, input int reset_at);
    int iss[$];
    int n2 = NDATA * NDATA;
    int c = 1;
    int last_res, done_c, last_cyc, ii, ir;
    logic exp_rd, exp_rv;
    while (iss.size() < n2) begin
      if (c >= 128 || !hold_pat[c]) iss.push_back(c);
      c++;
    end
    last_res = iss[n2-1] + LAT + 2;
    done_c   = last_res + 1;
    last_cyc = (reset_at >= 0) ? reset_at : done_c + 2;
    ii = 0;
    ir = 0;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      @(posedge clk);
      #1;
      i_start = (cyc == 0) || (start_always != 0 && cyc <= done_c);
      i_hold  = (cyc < 128) ? hold_pat[cyc] : 1'b0;
      reset   = (cyc == reset_at);
      #1;
      exp_rd = (ii < n2) && (iss[ii] == cyc);
      chk("rd_en", 32'(o_rd_en), 32'(exp_rd));
      if (exp_rd) begin
        chk("rd_row", 32'(o_rd_row), 32'(ii / NDATA));
        chk("rd_col", 32'(o_rd_col), 32'(ii % NDATA));
        ii++;
      end
      exp_rv = (ir < n2) && (iss[ir] + LAT + 2 == cyc);
      chk("res_valid", 32'(o_res_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("res_row", 32'(o_res_row), 32'(ir / NDATA));
        chk("res_col", 32'(o_res_col), 32'(ir % NDATA));
        chk("res_data", 32'(o_res_data), 32'(cref(ir / NDATA, ir % NDATA)));
        obs_c[ir / NDATA][ir % NDATA] = o_res_data;
        ir++;
      end
      chk("busy", 32'(o_busy), 32'(cyc >= 1 && cyc <= last_res));
      chk("done", 32'(o_done), 32'(cyc == done_c));
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    if (reset_at >= 0) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_rd_en", 32'(o_rd_en), 0);
      chk("rst_res_valid", 32'(o_res_valid), 0);
      chk("rst_res_data", 32'(o_res_data), 0);
      chk("rst_busy", 32'(o_busy), 0);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #2;
        chk("quiet_res_valid", 32'(o_res_valid), 0);
        chk("quiet_busy", 32'(o_busy), 0);
        chk("quiet_rd_en", 32'(o_rd_en), 0);
        chk("quiet_done", 32'(o_done), 0);
      end
    end
  endtask

  initial begin
    rand_mats();
    a1 = int'($urandom_range(15, 0));
    b1 = int'($urandom_range(15, 0));
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rd_en", 32'(o_rd_en), 0);
    chk("reset_res_valid", 32'(o_res_valid), 0);
    chk("reset_res_data", 32'(o_res_data), 0);
    chk("reset_res_row", 32'(o_res_row), 0);
    chk("reset_res_col", 32'(o_res_col), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_done", 32'(o_done), 0);
    chk("reset1_busy", 32'(s1_busy), 0);
    reset = 1'b0;

    for (int k = 0; k < NDATA; k++) begin
      A[0][k]  = k;
      Bc[0][k] = k;
      A[1][k]  = k + 4;
      Bc[1][k] = k + 4;
    end
    set_holds(0);
    run(0, -1);
    chk("c00_value", 32'(obs_c[0][0]), 14);
    chk("c11_value", 32'(obs_c[1][1]), 126);

    set_holds(1);
    run(0, -1);
    set_holds(0);
    run(1, -1);
    run(0, -1);

    for (int t = 0; t < 4; t++) begin
      rand_mats();
      set_holds(2);
      run(0, -1);
    end

    set_holds(0);
    run(0, 10);
    rand_mats();
    run(0, -1);

    for (int cyc = 0; cyc <= LAT + 6; cyc++) begin
      @(posedge clk);
      #1;
      s1_start = (cyc == 0);
      #1;
      chk("n1_rd_en", 32'(s1_rd_en), 32'(cyc == 1));
      if (cyc == 1) begin
        chk("n1_rd_row", 32'(s1_rd_row), 0);
        chk("n1_rd_col", 32'(s1_rd_col), 0);
      end
      chk("n1_res_valid", 32'(s1_res_valid), 32'(cyc == LAT + 3));
      if (cyc == LAT + 3) chk("n1_res_data", 32'(s1_res_data), 32'(RW'(a1 * b1)));
      chk("n1_done", 32'(s1_done), 32'(cyc == LAT + 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
